// File: rtl/controlador_mem_pkg.sv
// Shared encodings for the data-RAM initiator: FSM states, access-size codes, lane widths.
// No logic; imported by controlador_mem and alinhador_dados.
package controlador_mem_pkg;

    localparam logic [1:0] OCIOSO   = 2'd0;
    localparam logic [1:0] LER      = 2'd1;
    localparam logic [1:0] ESCREVER = 2'd2;
    localparam logic [1:0] RESP     = 2'd3;

    localparam logic [1:0] TAM_BYTE    = 2'b00;
    localparam logic [1:0] TAM_MEIA    = 2'b01;
    localparam logic [1:0] TAM_PALAVRA = 2'b10;
    localparam logic [1:0] TAM_RESERV  = 2'b11;

    localparam int LARG_BYTE = 8;
    localparam int LARG_MEIA = 16;

endpackage

// File: rtl/controlador_mem_alinhador_dados.sv
// Lane extract + sign/zero extend for loads, lane merge of store data into a read word.
// Purely combinational, zero latency; no flow control.
// Little-endian lanes: byte lane = faixa_i, half lane = faixa_i[1].
module alinhador_dados
    import controlador_mem_pkg::*;
(
    input  logic [1:0]  tamanho_i,
    input  logic        sinal_i,
    input  logic [1:0]  faixa_i,
    input  logic [31:0] palavra_i,
    input  logic [31:0] dados_st_i,
    output logic [31:0] carga_o,
    output logic [31:0] mesclada_o
);

    logic [7:0]  byte_l;
    logic [15:0] meia_l;

    always_comb begin
        byte_l     = palavra_i[{faixa_i, 3'b000} +: LARG_BYTE];
        meia_l     = palavra_i[{faixa_i[1], 4'b0000} +: LARG_MEIA];
        carga_o    = '0;
        mesclada_o = palavra_i;
        case (tamanho_i)
            TAM_BYTE: begin
                carga_o = {{24{sinal_i & byte_l[7]}}, byte_l};
                mesclada_o[{faixa_i, 3'b000} +: LARG_BYTE] = dados_st_i[7:0];
            end
            TAM_MEIA: begin
                carga_o = {{16{sinal_i & meia_l[15]}}, meia_l};
                mesclada_o[{faixa_i[1], 4'b0000} +: LARG_MEIA] = dados_st_i[15:0];
            end
            TAM_PALAVRA: begin
                carga_o    = palavra_i;
                mesclada_o = dados_st_i;
            end
            default: begin
                carga_o    = '0;
                mesclada_o = palavra_i;
            end
        endcase
    end

endmodule

// File: rtl/controlador_mem.sv
// Load/store initiator for a single-port word RAM, with byte/half support via read-modify-write.
// Latency accept->resp_valid: load 2, word store 2, sub-word store 3, error 1; one request in flight.
// req_ready only in OCIOSO; response held until resp_ready. MEM_CHECA_ALINHAMENTO_EN enables misalignment errors.
module controlador_mem
    import controlador_mem_pkg::*;
#(
    parameter int PROF_MEM = 1024,
    parameter int LARG_END = 32
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_escreve,
    input  logic [1:0]          req_tamanho,
    input  logic                req_sinal,
    input  logic [31:0]         req_endereco,
    input  logic [31:0]         req_dados,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [31:0]         resp_dados,
    output logic                resp_erro,
    output logic [LARG_END-1:0] mem_endereco,
    output logic [31:0]         mem_dados,
    output logic                mem_escreveMem,
    input  logic [31:0]         mem_dadosLidos
);

    logic [1:0]  estado_q, estado_d;
    logic        escreve_q, escreve_d;
    logic [1:0]  tam_q, tam_d;
    logic        sinal_q, sinal_d;
    logic [31:0] end_q, end_d;
    logic [31:0] mescl_q, mescl_d;
    logic [31:0] resp_dados_q, resp_dados_d;
    logic        resp_erro_q, resp_erro_d;

    logic [31:0] carga;
    logic [31:0] mesclada;
    logic        fora_faixa;
    logic        desalinhado;
    logic        erro_req;

    alinhador_dados u_alinhador (
        .tamanho_i  (tam_q),
        .sinal_i    (sinal_q),
        .faixa_i    (end_q[1:0]),
        .palavra_i  (mem_dadosLidos),
        .dados_st_i (mescl_q),
        .carga_o    (carga),
        .mesclada_o (mesclada)
    );

    assign fora_faixa = {2'b00, req_endereco[31:2]} >= 32'(PROF_MEM);

`ifdef MEM_CHECA_ALINHAMENTO_EN
    assign desalinhado = ((req_tamanho == TAM_MEIA) && req_endereco[0]) ||
                         ((req_tamanho == TAM_PALAVRA) && (req_endereco[1:0] != 2'b00));
`else
    assign desalinhado = 1'b0;
`endif

    assign erro_req = (req_tamanho == TAM_RESERV) || fora_faixa || desalinhado;

    always_comb begin
        estado_d     = estado_q;
        escreve_d    = escreve_q;
        tam_d        = tam_q;
        sinal_d      = sinal_q;
        end_d        = end_q;
        mescl_d      = mescl_q;
        resp_dados_d = resp_dados_q;
        resp_erro_d  = resp_erro_q;
        case (estado_q)
            OCIOSO: begin
                if (req_valid) begin
                    escreve_d = req_escreve;
                    tam_d     = req_tamanho;
                    sinal_d   = req_sinal;
                    end_d     = req_endereco;
                    // Holds raw store data until LER merges it into the read word.
                    mescl_d   = req_dados;
                    if (erro_req) begin
                        estado_d     = RESP;
                        resp_erro_d  = 1'b1;
                        resp_dados_d = '0;
                    end else if (req_escreve && (req_tamanho == TAM_PALAVRA)) begin
                        estado_d = ESCREVER;
                    end else begin
                        estado_d = LER;
                    end
                end
            end
            LER: begin
                if (escreve_q) begin
                    mescl_d  = mesclada;
                    estado_d = ESCREVER;
                end else begin
                    resp_dados_d = carga;
                    estado_d     = RESP;
                end
            end
            ESCREVER: begin
                estado_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    estado_d     = OCIOSO;
                    resp_dados_d = '0;
                    resp_erro_d  = 1'b0;
                end
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q     <= OCIOSO;
            escreve_q    <= 1'b0;
            tam_q        <= TAM_BYTE;
            sinal_q      <= 1'b0;
            end_q        <= '0;
            mescl_q      <= '0;
            resp_dados_q <= '0;
            resp_erro_q  <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            escreve_q    <= escreve_d;
            tam_q        <= tam_d;
            sinal_q      <= sinal_d;
            end_q        <= end_d;
            mescl_q      <= mescl_d;
            resp_dados_q <= resp_dados_d;
            resp_erro_q  <= resp_erro_d;
        end
    end

    // RAM-side outputs decode from state only, so reset kills a pending write immediately.
    assign req_ready      = (estado_q == OCIOSO);
    assign resp_valid     = (estado_q == RESP);
    assign resp_dados     = resp_dados_q;
    assign resp_erro      = resp_erro_q;
    assign mem_escreveMem = (estado_q == ESCREVER);
    assign mem_dados      = (estado_q == ESCREVER) ? mescl_q : '0;
    assign mem_endereco   = ((estado_q == LER) || (estado_q == ESCREVER)) ?
                            LARG_END'(end_q[31:2]) : '0;

endmodule
